// File: rtl/complete_cdb_arbiter.sv
// Complete stage: per-FU result FIFOs, round-robin CDB arbiter and registered PRF write port.
// Optional macro CDB_BYPASS_EN lets a fresh result skip its FIFO when every FIFO is empty.
module complete_cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int XLEN      = 32,
  parameter int PREG_W    = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*PREG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [PREG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]          cdb_data,
  output logic                     prf_write_en,
  output logic [PREG_W-1:0]        prf_write_tag,
  output logic [XLEN-1:0]          prf_write_data
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int IDX_W = $clog2(NUM_FU);
  localparam logic [IDX_W-1:0] LAST_FU = IDX_W'(NUM_FU - 1);

  logic [PREG_W-1:0] r_tag_mem  [NUM_FU][BUF_DEPTH];
  logic [XLEN-1:0]   r_data_mem [NUM_FU][BUF_DEPTH];
  logic [CNT_W-1:0]  r_count    [NUM_FU];
  logic [PTR_W-1:0]  r_head     [NUM_FU];
  logic [PTR_W-1:0]  r_tail     [NUM_FU];
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [PREG_W-1:0] r_cdb_tag;
  logic [XLEN-1:0]   r_cdb_data;

  logic [PREG_W-1:0] w_tag_in  [NUM_FU];
  logic [XLEN-1:0]   w_data_in [NUM_FU];
  logic [NUM_FU-1:0] w_tag_nz;
  logic [NUM_FU-1:0] w_ready;
  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_cand;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic              w_any_ne;
  logic              w_bypass;
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_rr_next;
  logic [PREG_W-1:0] w_win_tag;
  logic [XLEN-1:0]   w_win_data;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_tag_in[i]   = fu_tag[i*PREG_W +: PREG_W];
      w_data_in[i]  = fu_data[i*XLEN +: XLEN];
      w_tag_nz[i]   = (w_tag_in[i] != '0);
      w_ready[i]    = (r_count[i] < CNT_W'(BUF_DEPTH));
      w_nonempty[i] = (r_count[i] != '0);
    end
  end

  assign w_any_ne = |w_nonempty;

`ifdef CDB_BYPASS_EN
  // With every FIFO empty, live tagged results compete directly in the same rotation.
  assign w_bypass = !w_any_ne;
  assign w_cand   = w_any_ne ? w_nonempty : (fu_valid & w_tag_nz);
`else
  assign w_bypass = 1'b0;
  assign w_cand   = w_nonempty;
`endif

  // First candidate found scanning upward from rr_ptr, wrapping at NUM_FU.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_FU;
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  assign w_rr_next  = (w_win == LAST_FU) ? '0 : w_win + IDX_W'(1);
  assign w_win_tag  = w_bypass ? w_tag_in[w_win]  : r_tag_mem[w_win][r_head[w_win]];
  assign w_win_data = w_bypass ? w_data_in[w_win] : r_data_mem[w_win][r_head[w_win]];

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_push[i] = fu_valid[i] && w_ready[i] && !flush && w_tag_nz[i] &&
                  !(w_bypass && w_found && (w_win == IDX_W'(i)));
      w_pop[i]  = w_found && !w_bypass && (w_win == IDX_W'(i));
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the counters alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_tail[i]]  <= w_tag_in[i];
        r_data_mem[i][r_tail[i]] <= w_data_in[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_count[i] <= '0;
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
      end
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_count[i] <= '0;
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
      end
      r_cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_push[i]) r_tail[i] <= r_tail[i] + PTR_W'(1);
        if (w_pop[i])  r_head[i] <= r_head[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
      if (w_found) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_win_tag;
        r_cdb_data  <= w_win_data;
        r_rr_ptr    <= w_rr_next;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign fu_ready       = w_ready;
  assign cdb_valid      = r_cdb_valid;
  assign cdb_tag        = r_cdb_tag;
  assign cdb_data       = r_cdb_data;
  assign prf_write_en   = r_cdb_valid;
  assign prf_write_tag  = r_cdb_tag;
  assign prf_write_data = r_cdb_data;

endmodule

// File: tb/tb_complete_cdb_arbiter.sv
// Scoreboard bench for complete_cdb_arbiter: queue-based reference model, decoupled CDB monitor.
module tb_complete_cdb_arbiter;

  localparam int N = 4;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [N-1:0]  fu_valid;
  logic [N*6-1:0]  fu_tag;
  logic [N*32-1:0] fu_data;
  logic [N-1:0]  fu_ready;
  logic          cdb_valid;
  logic [5:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          prf_write_en;
  logic [5:0]    prf_write_tag;
  logic [31:0]   prf_write_data;

  complete_cdb_arbiter #(.NUM_FU(N), .BUF_DEPTH(DEPTH), .XLEN(32), .PREG_W(6)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .prf_write_en(prf_write_en), .prf_write_tag(prf_write_tag), .prf_write_data(prf_write_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [5:0] tag; logic [31:0] data; } ent_t;
  typedef struct { logic [5:0] tag; logic [31:0] data; int cyc; } exp_t;

  ent_t mq[N][$];
  exp_t expq[$];
  int   rr = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;
  bit   last_rst = 0;

  bit          pend_v [N];
  logic [5:0]  pend_t [N];
  logic [31:0] pend_d [N];
  bit          drv_rst = 0;
  bit          drv_flush = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every CDB broadcast must match the oldest outstanding expectation, in the right cycle.
  always @(negedge clock) begin
    if (mon_en && cdb_valid) begin
      exp_t e;
      if (expq.size() == 0) begin
        check("spurious_cdb_valid", 64'(cdb_tag), 64'h0);
        check("spurious_cdb_valid_flag", 64'(cdb_valid), 64'h0);
      end else begin
        e = expq.pop_front();
        check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
        check("cdb_data", 64'(cdb_data), 64'(e.data));
        check("cdb_cycle", 64'(cyc), 64'(e.cyc));
        check("prf_mirror", {31'd0, prf_write_en, prf_write_tag, prf_write_data},
              {31'd0, cdb_valid, cdb_tag, cdb_data});
      end
    end
  end

  task automatic load(input int i, input logic [5:0] t, input logic [31:0] d);
    pend_v[i] = 1'b1;
    pend_t[i] = t;
    pend_d[i] = d;
  endtask

  // One clock: check ready, drive pending results, advance the reference model for the coming edge.
  task automatic tick();
    logic [N-1:0] rdy, acc;
    bit any_ne, found, byp;
    int win, idx;
    ent_t e;
    @(negedge clock);
    if (last_rst) begin
      check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
      check("reset_cdb_tag", 64'(cdb_tag), 64'h0);
      check("reset_cdb_data", 64'(cdb_data), 64'h0);
    end
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < DEPTH);
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    reset = ~drv_rst;
    flush = drv_flush;
    for (int i = 0; i < N; i++) begin
      fu_valid[i] = pend_v[i];
      fu_tag[i*6 +: 6] = pend_t[i];
      fu_data[i*32 +: 32] = pend_d[i];
    end
    for (int i = 0; i < N; i++) acc[i] = pend_v[i] && rdy[i];
    if (drv_rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
    end else if (drv_flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      any_ne = 0;
      for (int i = 0; i < N; i++) if (mq[i].size() > 0) any_ne = 1;
      found = 0; win = 0; byp = 0;
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (!found) begin
          if (any_ne && mq[idx].size() > 0) begin found = 1; win = idx; end
`ifdef CDB_BYPASS_EN
          else if (!any_ne && acc[idx] && pend_t[idx] != 0) begin found = 1; win = idx; byp = 1; end
`endif
        end
      end
      if (found) begin
        if (byp) begin e.tag = pend_t[win]; e.data = pend_d[win]; end
        else e = mq[win].pop_front();
        expq.push_back('{tag: e.tag, data: e.data, cyc: cyc + 1});
        rr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (acc[i] && pend_t[i] != 0 && !(byp && win == i))
          mq[i].push_back('{tag: pend_t[i], data: pend_d[i]});
    end
    for (int i = 0; i < N; i++) if (acc[i] || drv_rst) pend_v[i] = 1'b0;
    last_rst = drv_rst;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    int nxt;
    reset = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
    for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_t[i] = '0; pend_d[i] = '0; end

    drv_rst = 1; tick(); drv_rst = 0;
    mon_en = 1;
    idle(2);

    // single result
    load(1, 6'd5, 32'hDEADBEEF); tick(); idle(4);

    // contention from rr_ptr = 0
    drv_rst = 1; tick(); drv_rst = 0;
    for (int i = 0; i < N; i++) load(i, 6'(10 + i), $urandom);
    tick(); idle(6);

    // backpressure on FU2 while FU0/FU1 stay busy
    nxt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin
        if (!pend_v[0]) load(0, 6'(40 + c), $urandom);
        if (!pend_v[1]) load(1, 6'(48 + c), $urandom);
      end
      if (!pend_v[2] && nxt < 3) begin load(2, 6'(20 + nxt), $urandom); nxt++; end
      tick();
    end
    idle(6);

    // tag 0 handshake, never broadcast
    load(3, 6'd0, 32'h1234); tick(); idle(3);

    // flush with buffered results
    load(0, 6'd30, 32'hA0); load(1, 6'd31, 32'hA1); tick();
    load(0, 6'd32, 32'hA2); tick();
    drv_flush = 1; tick(); drv_flush = 0;
    idle(4);

    // reset mid-operation, then a single result again
    for (int i = 0; i < N; i++) load(i, 6'(50 + i), $urandom);
    tick();
    load(0, 6'd54, $urandom); load(1, 6'd55, $urandom); tick();
    drv_rst = 1; tick(); drv_rst = 0;
    load(1, 6'd5, 32'hDEADBEEF); tick(); idle(4);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(99) < 45)
          load(i, ($urandom_range(9) == 0) ? 6'd0 : 6'($urandom_range(63)), $urandom);
      drv_flush = ($urandom_range(99) < 2);
      drv_rst   = ($urandom_range(999) < 5);
      tick();
    end
    drv_flush = 0; drv_rst = 0;
    idle(12);

    check("outstanding_expected", 64'(expq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/complete_cdb_arbiter.md
Name: complete_cdb_arbiter

Overview:
- Complete-stage block between the functional units and the physical register file (PRF) write port.
- Buffers finished results from NUM_FU functional units in per-unit FIFOs.
- Selects one result per cycle with round-robin arbitration and drives it, registered, onto the common data bus (CDB) and the PRF write port.
- Backpressures each FU individually when that FU's buffer is full.

Parameters:
- NUM_FU, 4, number of functional-unit result ports (≥2).
- BUF_DEPTH, 2, entries per FU result FIFO (power of 2, ≥2).
- XLEN, 32, result data width.
- PREG_W, 6, physical register index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- flush  in  1  branch-mispredict squash; clears all buffered results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_tag  in  NUM_FU*PREG_W  per-FU destination physical register; FU i occupies slice [i*PREG_W +: PREG_W].
- fu_data  in  NUM_FU*XLEN  per-FU result value; FU i occupies slice [i*XLEN +: XLEN].
- fu_ready  out  NUM_FU  per-FU accept; a result transfers when fu_valid[i] && fu_ready[i].
- cdb_valid  out  1  CDB broadcast valid; registered.
- cdb_tag  out  PREG_W  broadcast physical register; registered.
- cdb_data  out  XLEN  broadcast value; registered.
- prf_write_en  out  1  PRF write enable; equals cdb_valid.
- prf_write_tag  out  PREG_W  equals cdb_tag.
- prf_write_data  out  XLEN  equals cdb_data.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All FIFOs empty; count, head and tail pointers = 0.
  - rr_ptr = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0.
  - fu_ready is all-ones from the first cycle after reset.
  - Reset overrides flush and any enqueue or grant in the same cycle.
- fu_ready[i] = (count[i] < BUF_DEPTH).
  - Combinational from registered count only; no same-cycle pop-through when full.
- Enqueue: fu_valid[i] && fu_ready[i] && !flush writes {tag, data} at tail[i]; tail[i] wraps modulo BUF_DEPTH.
- Tag 0 results are accepted (the handshake completes) but are not buffered or broadcast.
- Arbitration, each cycle:
  - Candidates are the non-empty FIFOs.
  - Winner = first candidate scanning from rr_ptr upward, modulo NUM_FU.
  - The winner's head entry is popped and registered into cdb_* at the clock edge.
  - rr_ptr ← (winner+1) mod NUM_FU.
  - No candidates: cdb_valid ← 0; cdb_tag/cdb_data hold their previous values; rr_ptr unchanged.
- Simultaneous enqueue and pop on the same FIFO: count unchanged, both pointers advance.
- Latency (no optional feature): a result accepted at edge N is in the FIFO during cycle N+1 and on the CDB at the earliest in cycle N+2.
- Order: per-FU results retire in FIFO order. Ordering across FUs is by arbitration only.
- Throughput: at most one CDB broadcast per cycle. Starvation is bounded: any non-empty FIFO wins within NUM_FU grants.
- Flush:
  - At the edge, all FIFOs are emptied and cdb_valid ← 0.
  - Handshakes in the flush cycle are discarded (fu_ready stays per count; the FU must treat flushed results as squashed).
  - rr_ptr is unchanged.
- No internal state machine beyond the FIFOs and rr_ptr.
- Outputs never go X after reset.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - When no FIFO is non-empty, the arbiter also considers fu_valid[i] with tag≠0 directly, using the same round-robin order starting at rr_ptr.
  - The bypass winner is registered straight into cdb_* and is not enqueued. Other same-cycle valid FUs enqueue normally.
  - Single-result latency becomes 1 cycle: accepted at edge N, broadcast in cycle N+1.
- Undefined: every result passes through its FIFO, with the 2-cycle minimum latency above.

Test Plan:
- Single result: FU1 presents tag 5, data 0xDEADBEEF for one cycle after reset → cdb_valid=1 with tag 5, 0xDEADBEEF exactly 2 cycles later (1 with CDB_BYPASS_EN); prf_write_* mirror it.
- Contention: all 4 FUs present tags 10, 11, 12, 13 in the same cycle with rr_ptr=0 → CDB order 10, 11, 12, 13 on consecutive cycles; rr_ptr ends at 0.
- Backpressure: FU2 valid every cycle with tags 20, 21, 22 while FU0/FU1 are kept busy and win first → fu_ready[2] drops after 2 entries; no tag lost or duplicated; FU2 tags appear in order 20, 21, 22.
- Tag 0: FU3 presents tag 0, data 0x1234 → fu_ready[3]=1 and the handshake completes; no cdb_valid pulse.
- Flush: 3 results buffered across FU0/FU1, flush asserted for one cycle → next cycle cdb_valid=0, all fu_ready=1, and no buffered result ever appears on the CDB.
- Reset mid-operation: FIFOs half-full and cdb_valid=1, reset=0 for one cycle → cdb_valid=0 and cdb_tag=0 the next cycle; a subsequent single result behaves as in the first scenario.
